// File: rtl/float2fxp_stream.sv
// -----------------------------------------------------------------------------
// float2fxp_stream
//
// Streaming converter from IEEE-754 single precision to signed fixed point
// with WOI integer bits (sign included) and WOF fractional bits. It has three
// register stages:
//   S1  decode   : splits sign/exponent/mantissa and classifies the word
//                  (zero and denormal, normal, Inf, NaN)
//   S2  align    : scales the significand by 2^(e-150+WOF) and keeps a guard
//                  bit when shifting right
//   S3  finalize : rounds, saturates and applies the sign; S3 drives the
//                  outputs directly
// All three stages advance together whenever the output register is empty or
// is being drained. Bubbles are not squeezed out.
//
// Ports
//   clk         clock, rising edge
//   rstn        asynchronous active-low reset
//   i_valid     input word valid
//   i_ready     block accepts a word this cycle (= ~o_valid | o_ready)
//   i_float     IEEE-754 single-precision word
//   o_valid     output word valid
//   o_ready     downstream accepts the output word
//   o_fxp       signed fixed-point result, WOI+WOF bits
//   o_overflow  result saturated, or input was Inf/NaN
// -----------------------------------------------------------------------------
module float2fxp_stream #(
   parameter int WOI   = 13,
   parameter int WOF   = 13,
   parameter bit ROUND = 1'b1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_valid,
   output logic               i_ready,
   input  logic [31:0]        i_float,
   output logic               o_valid,
   input  logic               o_ready,
   output logic [WOI+WOF-1:0] o_fxp,
   output logic               o_overflow
);

   localparam int N = WOI + WOF;
   // The magnitude register must hold 2^(N-1) plus a rounding carry, and must
   // also hold a full 24-bit significand that has been shifted right.
   localparam int MW = (N + 1 > 25) ? N + 1 : 25;
   // Any left shift beyond this point pushes even the smallest significand
   // (2^23) above 2^(N-1).
   localparam int LSH_MAX = N - 24;

   localparam logic [N-1:0]  FXP_MAX    = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]  FXP_MIN    = {1'b1, {(N-1){1'b0}}};
   localparam logic [MW-1:0] HALF_RANGE = MW'(1) << (N - 1);   // 2^(N-1)
   localparam logic [MW-1:0] MAG_MAX    = HALF_RANGE - MW'(1);  // 2^(N-1)-1

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } cls_e;

   // ---------------------------------------------------------------- control
   logic adv;
   logic s1_v_q, s2_v_q, s3_v_q;

   // A stall exists only while the output word waits for its consumer, so the
   // whole pipe either moves or holds as one unit.
   assign adv     = ~s3_v_q | o_ready;
   assign i_ready = adv;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // stage samples the value its upstream stage held before the clock edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         s3_v_q <= 1'b0;
      end else if (adv) begin
         s1_v_q <= i_valid;
         s2_v_q <= s1_v_q;
         s3_v_q <= s2_v_q;
      end
   end

   // --------------------------------------------------------------- S1 decode
   cls_e        s1_cls_d, s1_cls_q;
   logic        s1_sign_q;
   logic [7:0]  s1_exp_q;
   logic [23:0] s1_sig_q;

   // NOTE: every combinational block assigns all of its outputs at the top,
   // so no path through the branches can leave a value unassigned and infer
   // a latch.
   always_comb begin
      s1_cls_d = CLS_NORM;
      if (i_float[30:23] == 8'h00) begin
         s1_cls_d = CLS_ZERO;                 // denormals flush to zero
      end else if (i_float[30:23] == 8'hFF) begin
         s1_cls_d = (i_float[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
      end
   end

   // ---------------------------------------------------------------- S2 align
   cls_e          s2_cls_q;
   logic          s2_sign_q;
   logic [MW-1:0] s2_mag_d, s2_mag_q;
   logic          s2_guard_d, s2_guard_q;
   logic          s2_povf_d, s2_povf_q;
   int            sh;
   logic [5:0]    rs;
   logic [24:0]   rwide;

   // Ties round half away from zero, so the bits below the guard bit never
   // change the result. A sticky bit would be redundant and is not carried.
   always_comb begin
      sh         = int'(s1_exp_q) + WOF - 150;
      rs         = '0;
      rwide      = '0;
      s2_mag_d   = '0;
      s2_guard_d = 1'b0;
      s2_povf_d  = 1'b0;
      if (sh > LSH_MAX) begin
         s2_povf_d = 1'b1;
      end else if (sh >= 0) begin
         s2_mag_d = MW'(s1_sig_q) << sh;
      end else begin
         // A shift of 25 or more leaves every bit, including the guard bit,
         // below the result. Capping the distance there stops any wrap.
         rs         = (sh < -25) ? 6'd25 : 6'(-sh);
         rwide      = {s1_sig_q, 1'b0} >> rs;
         s2_mag_d   = MW'(rwide[24:1]);
         s2_guard_d = rwide[0];
      end
      if (s2_mag_d > HALF_RANGE) begin
         s2_povf_d = 1'b1;
      end
   end

   // ------------------------------------------------------------- S3 finalize
   logic [N-1:0]  s3_fxp_d, s3_fxp_q;
   logic          s3_ovf_d, s3_ovf_q;
   logic [MW-1:0] mag_r;

   always_comb begin
      mag_r    = s2_mag_q + MW'(ROUND & s2_guard_q);
      s3_fxp_d = '0;
      s3_ovf_d = 1'b0;
      unique case (s2_cls_q)
         CLS_ZERO: begin
            s3_fxp_d = '0;
            s3_ovf_d = 1'b0;
         end
         CLS_NAN: begin
            s3_fxp_d = FXP_MAX;
            s3_ovf_d = 1'b1;
         end
         CLS_INF: begin
            s3_fxp_d = s2_sign_q ? FXP_MIN : FXP_MAX;
            s3_ovf_d = 1'b1;
         end
         CLS_NORM: begin
            if (s2_povf_q) begin
               s3_fxp_d = s2_sign_q ? FXP_MIN : FXP_MAX;
               s3_ovf_d = 1'b1;
            end else if (!s2_sign_q) begin
               if (mag_r > MAG_MAX) begin
                  s3_fxp_d = FXP_MAX;
                  s3_ovf_d = 1'b1;
               end else begin
                  s3_fxp_d = mag_r[N-1:0];
               end
            end else begin
               // A magnitude of exactly 2^(N-1) negates to MIN, which is
               // representable, so it is not flagged.
               if (mag_r > HALF_RANGE) begin
                  s3_fxp_d = FXP_MIN;
                  s3_ovf_d = 1'b1;
               end else begin
                  s3_fxp_d = -mag_r[N-1:0];
               end
            end
         end
         default: begin
            s3_fxp_d = '0;
            s3_ovf_d = 1'b0;
         end
      endcase
   end

   // --------------------------------------------------------------- registers
   // NOTE: the S1/S2 data registers have no reset. Their contents matter only
   // when the valid bit travelling with them is set, and that valid bit is
   // reset.
   always_ff @(posedge clk) begin
      if (adv && i_valid) begin
         s1_cls_q  <= s1_cls_d;
         s1_sign_q <= i_float[31];
         s1_exp_q  <= i_float[30:23];
         s1_sig_q  <= {1'b1, i_float[22:0]};
      end
      if (adv && s1_v_q) begin
         s2_cls_q   <= s1_cls_q;
         s2_sign_q  <= s1_sign_q;
         s2_mag_q   <= s2_mag_d;
         s2_guard_q <= s2_guard_d;
         s2_povf_q  <= s2_povf_d;
      end
   end

   // The output data registers are visible at the ports, so they are reset.
   // They load only real words, so o_fxp holds its value through bubbles.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s3_fxp_q <= '0;
         s3_ovf_q <= 1'b0;
      end else if (adv && s2_v_q) begin
         s3_fxp_q <= s3_fxp_d;
         s3_ovf_q <= s3_ovf_d;
      end
   end

   assign o_valid    = s3_v_q;
   assign o_fxp      = s3_fxp_q;
   assign o_overflow = s3_ovf_q;

endmodule

// File: tb/tb_float2fxp_stream.sv
// -----------------------------------------------------------------------------
// tb_float2fxp_stream
//
// Self-checking bench for float2fxp_stream with WOI=13 and WOF=13. It uses one
// instance with ROUND=1 and one with ROUND=0. Both instances share every
// input, so their handshakes run in lockstep. Expected results come either
// from directed constants or from a real-arithmetic reference model of the
// conversion rules.
// -----------------------------------------------------------------------------
module tb_float2fxp_stream;

   localparam int N = 26;
   typedef logic [N:0] res_t;               // {overflow, fxp}

   localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

   logic         clk = 1'b0;
   logic         rstn;
   logic         i_valid;
   logic         o_ready;
   logic [31:0]  i_float;
   logic         i_ready1, o_valid1, ovf1;
   logic         i_ready0, o_valid0, ovf0;
   logic [N-1:0] fxp1, fxp0;

   int total = 0;
   int bad   = 0;

   initial forever #5 clk = ~clk;

   float2fxp_stream #(.WOI(13), .WOF(13), .ROUND(1'b1)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .i_valid   (i_valid),
      .i_ready   (i_ready1),
      .i_float   (i_float),
      .o_valid   (o_valid1),
      .o_ready   (o_ready),
      .o_fxp     (fxp1),
      .o_overflow(ovf1)
   );

   float2fxp_stream #(.WOI(13), .WOF(13), .ROUND(1'b0)) dut_t (
      .clk       (clk),
      .rstn      (rstn),
      .i_valid   (i_valid),
      .i_ready   (i_ready0),
      .i_float   (i_float),
      .o_valid   (o_valid0),
      .o_ready   (o_ready),
      .o_fxp     (fxp0),
      .o_overflow(ovf0)
   );

   // ------------------------------------------------------- reference model
   function automatic real pow2(input int k);
      real r = 1.0;
      if (k >= 0) begin
         for (int i = 0; i < k; i++) r = r * 2.0;
      end else begin
         for (int i = 0; i < -k; i++) r = r / 2.0;
      end
      return r;
   endfunction

   // The real value of the float times 2^13, rounded as selected, then
   // clamped to the signed 26-bit range.
   function automatic res_t model(input logic [31:0] w, input bit rnd);
      bit     s;
      int     e;
      int     f;
      real    mag;
      longint m;
      s = w[31];
      e = int'(w[30:23]);
      f = int'(w[22:0]);
      if (e == 0) return {1'b0, {N{1'b0}}};
      if (e == 255) begin
         if (f != 0 || !s) return {1'b1, MAXV};
         return {1'b1, MINV};
      end
      mag = (1.0 + real'(f) / 8388608.0) * pow2(e - 127 + 13);
      mag = rnd ? $floor(mag + 0.5) : $floor(mag);
      if (!s) begin
         if (mag > pow2(N - 1) - 1.0) return {1'b1, MAXV};
         m = longint'($rtoi(mag));
         return {1'b0, N'(m)};
      end
      if (mag > pow2(N - 1)) return {1'b1, MINV};
      m = longint'($rtoi(mag));
      return {1'b0, N'(-m)};
   endfunction

   function automatic res_t r(input bit ovf, input logic [N-1:0] v);
      return {ovf, v};
   endfunction

   function automatic logic [31:0] rand_word();
      int         k;
      logic [7:0] e;
      logic [22:0] f;
      k = int'($urandom_range(15));
      f = 23'($urandom);
      if (k == 0) begin
         e = 8'h00;
      end else if (k == 1) begin
         e = 8'hFF;
         if ($urandom_range(1) == 0) f = '0;
      end else begin
         e = 8'($urandom_range(165, 95));
      end
      return {1'($urandom), e, f};
   endfunction

   // ------------------------------------------------------------- stream core
   // Call this at posedge+1. It streams 'words', drains every result and
   // checks each output against the next expected value in order. If exp1/exp0
   // are non-empty they hold the directed expectations; otherwise the model
   // supplies them. It also checks the handshake rule, output stability under
   // stall and, optionally, the 3-cycle latency.
   task automatic run_stream(input string name, input logic [31:0] words[$],
                             input res_t exp1[$], input res_t exp0[$],
                             input int ready_pct, input bit check_lat);
      res_t         q1[$];
      res_t         q0[$];
      int           acc_it[$];
      int           sent = 0;
      int           got  = 0;
      int           it   = 0;
      int           a;
      bit           stalled = 1'b0;
      logic [N-1:0] held_fxp = '0;
      logic         held_ovf = 1'b0;
      logic         want_rdy;
      res_t         e1, e0;
      while ((sent < words.size() || got < words.size()) && it < 3000) begin
         if (stalled) begin
            total++;
            if (o_valid1 !== 1'b1 || fxp1 !== held_fxp || ovf1 !== held_ovf) begin
               bad++;
               $display("FAIL %s stall_hold: got v=%b fxp=%h ovf=%b, want v=1 fxp=%h ovf=%b",
                        name, o_valid1, fxp1, ovf1, held_fxp, held_ovf);
            end
         end
         o_ready = ($urandom_range(99) < ready_pct);
         i_valid = (sent < words.size());
         i_float = i_valid ? words[sent] : $urandom;
         @(negedge clk);
         want_rdy = ~o_valid1 | o_ready;
         total++;
         if (i_ready1 !== want_rdy || i_ready0 !== want_rdy) begin
            bad++;
            $display("FAIL %s i_ready: got %b/%b, want %b", name, i_ready1, i_ready0, want_rdy);
         end
         if (o_valid1 === 1'b1 && o_ready) begin
            if (q1.size() == 0) begin
               total++;
               bad++;
               $display("FAIL %s extra_output: got fxp=%h with nothing expected", name, fxp1);
            end else begin
               e1 = q1.pop_front();
               e0 = q0.pop_front();
               a  = acc_it.pop_front();
               total++;
               if ({ovf1, fxp1} !== e1) begin
                  bad++;
                  $display("FAIL %s round1 #%0d: got ovf=%b fxp=%h, want ovf=%b fxp=%h",
                           name, got, ovf1, fxp1, e1[N], e1[N-1:0]);
               end
               total++;
               if (o_valid0 !== 1'b1 || {ovf0, fxp0} !== e0) begin
                  bad++;
                  $display("FAIL %s trunc #%0d: got v=%b ovf=%b fxp=%h, want v=1 ovf=%b fxp=%h",
                           name, got, o_valid0, ovf0, fxp0, e0[N], e0[N-1:0]);
               end
               if (check_lat) begin
                  total++;
                  if (it - a !== 3) begin
                     bad++;
                     $display("FAIL %s latency #%0d: got %0d cycles, want 3", name, got, it - a);
                  end
               end
               got++;
            end
         end
         stalled  = (o_valid1 === 1'b1) && !o_ready;
         held_fxp = fxp1;
         held_ovf = ovf1;
         if (i_valid && i_ready1) begin
            q1.push_back(exp1.size() > 0 ? exp1[sent] : model(words[sent], 1'b1));
            q0.push_back(exp0.size() > 0 ? exp0[sent] : model(words[sent], 1'b0));
            acc_it.push_back(it);
            sent++;
         end
         @(posedge clk);
         #1;
         it++;
      end
      i_valid = 1'b0;
      total++;
      if (sent != words.size() || got != words.size()) begin
         bad++;
         $display("FAIL %s timeout: sent=%0d got=%0d, want %0d", name, sent, got, words.size());
      end
      total++;
      if (o_valid1 !== 1'b0) begin
         bad++;
         $display("FAIL %s drain_empty: got o_valid=%b, want 0", name, o_valid1);
      end
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rstn    = 1'b0;
      i_valid = 1'b0;
      i_float = '0;
      o_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (o_valid1 !== 1'b0 || fxp1 !== '0 || ovf1 !== 1'b0 || o_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got v=%b fxp=%h ovf=%b, want v=0 fxp=0 ovf=0",
                  o_valid1, fxp1, ovf1);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (i_ready1 !== 1'b1 || o_valid1 !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got i_ready=%b o_valid=%b, want 1 0", i_ready1, o_valid1);
      end
   endtask

   task automatic test_exact();
      logic [31:0] w[$];
      res_t        e[$];
      w = '{32'h3F800000, 32'hC0000000, 32'h00000000, 32'h80000000};
      e = '{r(0, 26'h0002000), r(0, 26'h3FFC000), r(0, 26'h0), r(0, 26'h0)};
      run_stream("exact", w, e, e, 100, 1'b1);
   endtask

   task automatic test_rounding();
      logic [31:0] w[$];
      res_t        e1[$];
      res_t        e0[$];
      w  = '{32'h44696E31, 32'hC4696E31, 32'h33800000};
      e1 = '{r(0, 26'h074B719), r(0, 26'h38B48E7), r(0, 26'h0)};
      e0 = '{r(0, 26'h074B718), r(0, 26'h38B48E8), r(0, 26'h0)};
      run_stream("rounding", w, e1, e0, 100, 1'b1);
   endtask

   task automatic test_saturation();
      logic [31:0] w[$];
      res_t        e[$];
      w = '{32'h45800000, 32'hC5800000, 32'hC5800800, 32'h7F800000, 32'hFF800000,
            32'h7FC00000, 32'hFFC00001, 32'h457FFFFF, 32'h00000001, 32'h7F7FFFFF};
      e = '{r(1, MAXV), r(0, MINV), r(1, MINV), r(1, MAXV), r(1, MINV),
            r(1, MAXV), r(1, MAXV), r(0, 26'h1FFFFFE), r(0, 26'h0), r(1, MAXV)};
      run_stream("saturation", w, e, e, 100, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [31:0] w[$];
      res_t        none[$];
      for (int i = 0; i < 8; i++) w.push_back(rand_word());
      run_stream("backpressure", w, none, none, 55, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] w[$];
      res_t        none[$];
      for (int i = 0; i < 200; i++) w.push_back(rand_word());
      run_stream("random", w, none, none, 75, 1'b0);
   endtask

   task automatic test_reset_midstream();
      logic [31:0] w[$];
      res_t        none[$];
      o_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_valid = 1'b1;
         i_float = 32'h3F800000 + 32'(i);
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;
      total++;
      if (o_valid1 !== 1'b1) begin
         bad++;
         $display("FAIL midreset_fill: got o_valid=%b, want 1", o_valid1);
      end
      #2;
      rstn = 1'b0;
      #1;
      total++;
      if (o_valid1 !== 1'b0 || o_valid0 !== 1'b0 || fxp1 !== '0 || ovf1 !== 1'b0) begin
         bad++;
         $display("FAIL midreset_async: got v=%b/%b fxp=%h ovf=%b, want v=0/0 fxp=0 ovf=0",
                  o_valid1, o_valid0, fxp1, ovf1);
      end
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      w = '{32'hC1200000, 32'h40490FDB, 32'h3A800000};
      run_stream("post_reset", w, none, none, 100, 1'b1);
   endtask

   initial begin
      test_reset();
      test_exact();
      test_rounding();
      test_saturation();
      test_backpressure();
      test_random();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
